// File: rtl/radix4_booth_multiplier.sv
// Sequential radix-4 Booth multiplier with signed/unsigned mode and valid/ready handshakes.
// Optional early termination is enabled by defining BOOTH_EARLY_TERM_EN.
module radix4_booth_multiplier #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           tc,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int unsigned EW = N + 2;
    localparam int unsigned AW = N + 4;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned SW = $clog2(N / 2 + 2);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [EW-1:0]   mcand_q;
    logic [EW-1:0]   mplier_q;
    logic            overlap_q;
    logic [AW-1:0]   acc_q;
    logic [SW-1:0]   step_q;
    logic [PW-1:0]   product_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [AW-1:0]   mcand_x;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_next;
    logic [EW-1:0]   mplier_next;
    logic [PW-1:0]   final_res;

    always_comb begin
        mcand_x = {{2{mcand_q[EW-1]}}, mcand_q};
        addend  = '0;
        // Booth digit from {m[1], m[0], overlap}
        unique case ({mplier_q[1:0], overlap_q})
            3'b000, 3'b111: addend = '0;
            3'b001, 3'b010: addend = mcand_x;
            3'b011:         addend = {mcand_x[AW-2:0], 1'b0};
            3'b100:         addend = -{mcand_x[AW-2:0], 1'b0};
            3'b101, 3'b110: addend = -mcand_x;
            default:        addend = '0;
        endcase
        sum         = acc_q + addend;
        acc_next    = {{2{sum[AW-1]}}, sum[AW-1:2]};
        mplier_next = {sum[1:0], mplier_q[EW-1:2]};
        final_res   = {acc_next[N-3:0], mplier_next};
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [SW:0]            shamt;
    logic [EW-1:0]          early_mask;
    logic signed [AW+EW-1:0] chain_s;
    logic [PW-1:0]          early_prod;
    logic                   early_hit;

    always_comb begin
        shamt      = {step_q, 1'b0};
        // Low 2*S multiplier bits are still unprocessed
        early_mask = ~({EW{1'b1}} << shamt);
        early_hit  = (((mplier_q & early_mask) == '0) && !overlap_q) ||
                     (((mplier_q | ~early_mask) == '1) && overlap_q);
        chain_s    = {acc_q, mplier_q};
        early_prod = PW'(chain_s >>> shamt);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            overlap_q   <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mcand_q   <= tc ? {{2{a[N-1]}}, a} : {2'b00, a};
                        mplier_q  <= tc ? {{2{b[N-1]}}, b} : {2'b00, b};
                        overlap_q <= 1'b0;
                        acc_q     <= '0;
                        step_q    <= SW'(N / 2 + 1);
                        busy_q    <= 1'b1;
                        state_q   <= StCalc;
                    end
                end
                StCalc: begin
`ifdef BOOTH_EARLY_TERM_EN
                    if (early_hit) begin
                        product_q   <= early_prod;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StDone;
                    end else begin
`else
                    begin
`endif
                        acc_q     <= acc_next;
                        mplier_q  <= mplier_next;
                        overlap_q <= mplier_q[1];
                        step_q    <= step_q - SW'(1);
                        if (step_q == SW'(1)) begin
                            product_q   <= final_res;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Directed self-checking bench for radix4_booth_multiplier at N=8.
// Latency expectations follow BOOTH_EARLY_TERM_EN when it is defined.
module tb_radix4_booth_multiplier;

    localparam int unsigned N = 8;

`ifdef BOOTH_EARLY_TERM_EN
    localparam int LatFd = 3, Lat8080 = 5, LatFfff = 5, Lat8002 = 3, LatBp = 5, LatF00f = 4;
    localparam int Lat00 = 1, Lat01 = 2, LatFf = 2, Lat55 = 5, LatRand = -1;
`else
    localparam int LatFd = 5, Lat8080 = 5, LatFfff = 5, Lat8002 = 5, LatBp = 5, LatF00f = 5;
    localparam int Lat00 = 5, Lat01 = 5, LatFf = 5, Lat55 = 5, LatRand = 5;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           tc;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int total = 0;
    int bad   = 0;

    radix4_booth_multiplier #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .tc       (tc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid; returns cycles waited and cycles busy was seen high.
    task automatic wait_valid(output int n, output int bcnt);
        n = 0;
        bcnt = 0;
        while (!out_valid && n < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic tcv);
        in_valid = 1'b1; a = av; b = bv; tc = tcv;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 'x; b = 'x; tc = 1'bx;
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic tcv,
                          input logic [15:0] expv, input int lat, input string tag);
        int n, bcnt;
        accept(av, bv, tcv);
        chk({tag, "_inready_low"}, in_ready, 0);
        wait_valid(n, bcnt);
        if (lat >= 0) begin
            chk({tag, "_lat"}, n, lat);
            chk({tag, "_busycnt"}, bcnt, lat);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_prod"}, product, expv);
        @(posedge clk); #1;
        chk({tag, "_ready_back"}, in_ready, 1);
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int n, bcnt;
        logic [7:0]  ra, rb;
        logic        rtc;
        logic [15:0] rexp;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_inready", in_ready, 1);
        chk("rst_outvalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 16'h0000);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, LatFd, "m3x5");
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, Lat8080, "minxmin");
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, LatFfff, "maxxmax");
        run_op(8'h80, 8'h02, 1'b0, 16'h0100, Lat8002, "u80x2");

        // back-pressure
        out_ready = 1'b0;
        accept(8'h12, 8'h34, 1'b0);
        wait_valid(n, bcnt);
        chk("bp_lat", n, LatBp);
        chk("bp_prod", product, 16'h03A8);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_prod", product, 16'h03A8);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_inready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_inready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        run_op(8'hF0, 8'h0F, 1'b1, 16'hFF10, LatF00f, "bp_second");

        // flush two cycles after accept
        accept(8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_inready", in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_prod_kept", product, 16'hFF10);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("flush_valid_stays", out_valid, 0);
        end

        // async reset mid-calculation
        accept(8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_inready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_prod", product, 16'h0000);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h07, 8'h00, 1'b1, 16'h0000, Lat00, "x7_b00");
        run_op(8'h07, 8'h01, 1'b1, 16'h0007, Lat01, "x7_b01");
        run_op(8'h07, 8'hFF, 1'b1, 16'hFFF9, LatFf, "x7_bff");
        run_op(8'h07, 8'h55, 1'b1, 16'h0253, Lat55, "x7_b55");

        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rtc = 1'(i % 2);
            if (rtc) rexp = {{8{ra[7]}}, ra} * {{8{rb[7]}}, rb};
            else     rexp = {8'h00, ra} * {8'h00, rb};
            run_op(ra, rb, rtc, rexp, LatRand, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
